hamming_rx_deserializer: RTL and testbench

//   Serial-to-parallel receive stage sitting directly upstream of the SECDED decoder.

---
 rtl/hamming_rx_deserializer_if.sv | 31 +++
 rtl/hamming_rx_deserializer.sv | 152 +++++++++++++++
 tb/tb_hamming_rx_deserializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_rx_deserializer_if.sv
// Interface: hamming_rx_deserializer_if
// Bundles the serial channel input, the codeword handshake toward the SECDED decoder,
// and the status flags of the receive deserializer.
//   ser_valid/ser_bit/ser_sof : serial channel, no backpressure
//   cw_out[16:1]/cw_valid     : assembled codeword toward the decoder
//   cw_ready                  : decoder accepts cw_out when cw_valid && cw_ready
//   busy/frame_err/overrun    : status (frame_err/overrun are single-cycle pulses)
// Modports:
//   master : channel/decoder side (drives serial bits and cw_ready)
//   slave  : the deserializer itself
interface hamming_rx_deserializer_if;
    logic        ser_valid;
    logic        ser_bit;
    logic        ser_sof;
    logic [16:1] cw_out;
    logic        cw_valid;
    logic        cw_ready;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    modport master (
        output ser_valid, ser_bit, ser_sof, cw_ready,
        input  cw_out, cw_valid, busy, frame_err, overrun
    );

    modport slave (
        input  ser_valid, ser_bit, ser_sof, cw_ready,
        output cw_out, cw_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/hamming_rx_deserializer.sv
// Module: hamming_rx_deserializer
// Serial-to-parallel receive stage ahead of the SECDED (16,11) decoder. Collects a framed
// serial bitstream into a 16-bit codeword [16:1] and hands it over through valid/ready.
// Bits are passed through unmodified; no parity checking happens here.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : slave modport of hamming_rx_deserializer_if (serial in, codeword out, flags)
// Parameters:
//   CW_BITS   : codeword length, fixed at 16
//   TIMEOUT   : idle clocks between bits inside a frame before the frame is aborted (>=2)
//   LSB_FIRST : 1 -> first serial bit lands in cw_out[1]; 0 -> first bit lands in cw_out[16]
module hamming_rx_deserializer #(
    parameter int unsigned CW_BITS   = 16,
    parameter int unsigned TIMEOUT   = 32,
    parameter int unsigned LSB_FIRST = 1
) (
    input logic                     clk,
    input logic                     rst,
    hamming_rx_deserializer_if.slave bus
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CW_BITS:1]   sr_q, sr_d;
    logic [CW_BITS:1]   cw_out_q, cw_out_d;
    logic               cw_valid_q, cw_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               slot_free;
    logic               busy;

    // Map the serial index (0 = first bit of the frame) onto a codeword position.
    function automatic logic [4:0] pos_of(input logic [4:0] idx);
        if (LSB_FIRST != 0) begin
            return idx + 5'd1;
        end
        return 5'(CW_BITS) - idx;
    endfunction

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmo_q       <= '0;
            sr_q        <= '0;
            cw_out_q    <= '0;
            cw_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sr_q        <= sr_d;
            cw_out_q    <= cw_out_d;
            cw_valid_q  <= cw_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        sr_d        = sr_q;
        cw_out_d    = cw_out_q;
        cw_valid_d  = cw_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Slot counts as free if the held word is handed over in this very cycle.
        slot_free = !cw_valid_q || bus.cw_ready;
        if (cw_valid_q && bus.cw_ready) begin
            cw_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (bus.ser_valid) begin
                    if (bus.ser_sof) begin
                        sr_d                = '0;
                        sr_d[pos_of(5'd0)]  = bus.ser_bit;
                        cnt_d               = 5'd1;
                        state_d             = StShift;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (bus.ser_valid) begin
                    tmo_d = '0;
                    if (bus.ser_sof) begin
                        // Premature SOF restarts the frame; beats a coincident timeout.
                        frame_err_d         = 1'b1;
                        sr_d                = '0;
                        sr_d[pos_of(5'd0)]  = bus.ser_bit;
                        cnt_d               = 5'd1;
                    end else begin
                        sr_d[pos_of(cnt_q)] = bus.ser_bit;
                        if (cnt_q == 5'(CW_BITS - 1)) begin
                            cnt_d   = '0;
                            state_d = StIdle;
                            if (slot_free) begin
                                cw_out_d   = sr_d;
                                cw_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy = (state_q == StShift);
    end

    assign bus.busy      = busy;
    assign bus.cw_out    = cw_out_q;
    assign bus.cw_valid  = cw_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Directed bench: one LSB-first and one MSB-first instance receive the same codewords
// (each streamed in its own bit order), so both must present identical results.
module tb_hamming_rx_deserializer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    hamming_rx_deserializer_if if_l ();
    hamming_rx_deserializer_if if_m ();

    hamming_rx_deserializer #(.CW_BITS(16), .TIMEOUT(32), .LSB_FIRST(1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (if_l.slave)
    );

    hamming_rx_deserializer #(.CW_BITS(16), .TIMEOUT(32), .LSB_FIRST(0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        if_l.cw_ready = r;
        if_m.cw_ready = r;
    endtask

    task automatic idle(input int n);
        if_l.ser_valid = 1'b0;
        if_m.ser_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stream serial positions lo..hi of word; position 1 carries SOF. The LSB-first
    // instance gets word[i], the MSB-first instance gets word[17-i].
    task automatic send_bits(input logic [16:1] word, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if_l.ser_valid = 1'b1;
            if_m.ser_valid = 1'b1;
            if_l.ser_sof   = (i == 1);
            if_m.ser_sof   = (i == 1);
            if_l.ser_bit   = word[i];
            if_m.ser_bit   = word[17-i];
            tick();
        end
        if_l.ser_valid = 1'b0;
        if_m.ser_valid = 1'b0;
        if_l.ser_sof   = 1'b0;
        if_m.ser_sof   = 1'b0;
    endtask

    task automatic drain();
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        if_l.ser_valid = 1'b0; if_l.ser_bit = 1'b0; if_l.ser_sof = 1'b0; if_l.cw_ready = 1'b0;
        if_m.ser_valid = 1'b0; if_m.ser_bit = 1'b0; if_m.ser_sof = 1'b0; if_m.cw_ready = 1'b0;
        tick();
        tick();
        chk("rst_cw_out",    if_l.cw_out, 16'h0000);
        chk("rst_cw_valid",  16'(if_l.cw_valid), 16'h0);
        chk("rst_busy",      16'(if_l.busy), 16'h0);
        chk("rst_frame_err", 16'(if_l.frame_err), 16'h0);
        chk("rst_overrun",   16'(if_l.overrun), 16'h0);
        rst = 1'b0;
        tick();

        // T1 / T2: single frame, both bit orders.
        send_bits(16'h8007, 1, 15);
        chk("t1_busy_mid",   16'(if_l.busy), 16'h1);
        chk("t1_valid_early", 16'(if_l.cw_valid), 16'h0);
        send_bits(16'h8007, 16, 16);
        chk("t1_cw_valid",   16'(if_l.cw_valid), 16'h1);
        chk("t1_cw_out",     if_l.cw_out, 16'h8007);
        chk("t1_busy_low",   16'(if_l.busy), 16'h0);
        chk("t2_msb_cw_out", if_m.cw_out, 16'h8007);
        chk("t2_msb_valid",  16'(if_m.cw_valid), 16'h1);
        drain();
        chk("t1_drained",    16'(if_l.cw_valid), 16'h0);

        // T3: overrun with back-to-back frames while decoder stalls.
        send_bits(16'h8007, 1, 16);
        chk("t3_first_valid", 16'(if_l.cw_valid), 16'h1);
        send_bits(16'h0000, 1, 16);
        chk("t3_overrun",    16'(if_l.overrun), 16'h1);
        chk("t3_cw_held",    if_l.cw_out, 16'h8007);
        chk("t3_msb_overrun", 16'(if_m.overrun), 16'h1);
        idle(1);
        chk("t3_overrun_pulse", 16'(if_l.overrun), 16'h0);
        chk("t3_still_valid", 16'(if_l.cw_valid), 16'h1);
        drain();
        chk("t3_valid_drop", 16'(if_l.cw_valid), 16'h0);
        idle(1);
        chk("t3_stays_low",  16'(if_l.cw_valid), 16'h0);

        // T4: stray bit in IDLE, then premature SOF.
        send_bits(16'h0002, 2, 2);
        chk("t4_stray_err",  16'(if_l.frame_err), 16'h1);
        chk("t4_stray_busy", 16'(if_l.busy), 16'h0);
        idle(1);
        chk("t4_err_pulse",  16'(if_l.frame_err), 16'h0);
        send_bits(16'h1234, 1, 7);
        chk("t4_partial_busy", 16'(if_l.busy), 16'h1);
        send_bits(16'hA5C3, 1, 1);
        chk("t4_sof_err",    16'(if_l.frame_err), 16'h1);
        chk("t4_sof_busy",   16'(if_l.busy), 16'h1);
        send_bits(16'hA5C3, 2, 16);
        chk("t4_cw_valid",   16'(if_l.cw_valid), 16'h1);
        chk("t4_cw_out",     if_l.cw_out, 16'hA5C3);
        chk("t4_msb_cw_out", if_m.cw_out, 16'hA5C3);
        chk("t4_no_err",     16'(if_l.frame_err), 16'h0);
        drain();

        // T5: timeout after 32 idle clocks; 31-clock gap survives.
        send_bits(16'hFFFF, 1, 6);
        idle(31);
        chk("t5_busy_31",    16'(if_l.busy), 16'h1);
        chk("t5_no_err_31",  16'(if_l.frame_err), 16'h0);
        idle(1);
        chk("t5_tmo_err",    16'(if_l.frame_err), 16'h1);
        chk("t5_tmo_idle",   16'(if_l.busy), 16'h0);
        idle(1);
        chk("t5_tmo_pulse",  16'(if_l.frame_err), 16'h0);
        send_bits(16'h3C5A, 1, 8);
        idle(31);
        chk("t5_gap_no_err", 16'(if_l.frame_err), 16'h0);
        send_bits(16'h3C5A, 9, 16);
        chk("t5_gap_valid",  16'(if_l.cw_valid), 16'h1);
        chk("t5_gap_cw_out", if_l.cw_out, 16'h3C5A);
        chk("t5_gap_msb",    if_m.cw_out, 16'h3C5A);

        // T6: reset mid-frame while a word is held.
        send_bits(16'hC0DE, 1, 9);
        rst = 1'b1;
        #1;
        chk("t6_rst_cw_out", if_l.cw_out, 16'h0000);
        chk("t6_rst_valid",  16'(if_l.cw_valid), 16'h0);
        chk("t6_rst_busy",   16'(if_l.busy), 16'h0);
        chk("t6_rst_err",    16'(if_l.frame_err), 16'h0);
        chk("t6_rst_ovr",    16'(if_l.overrun), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        send_bits(16'h6E91, 1, 16);
        chk("t6_new_valid",  16'(if_l.cw_valid), 16'h1);
        chk("t6_new_cw_out", if_l.cw_out, 16'h6E91);

        // Same-cycle refill: handshake coincides with the 16th bit of the next frame.
        send_bits(16'h0F0F, 1, 15);
        chk("t6_held_valid", 16'(if_l.cw_valid), 16'h1);
        chk("t6_held_cw",    if_l.cw_out, 16'h6E91);
        set_ready(1'b1);
        send_bits(16'h0F0F, 16, 16);
        chk("t6_refill_valid", 16'(if_l.cw_valid), 16'h1);
        chk("t6_refill_cw",  if_l.cw_out, 16'h0F0F);
        chk("t6_refill_ovr", 16'(if_l.overrun), 16'h0);
        chk("t6_refill_msb", if_m.cw_out, 16'h0F0F);
        tick();
        chk("t6_final_drop", 16'(if_l.cw_valid), 16'h0);
        set_ready(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
